dco_ctrl_enc: RTL and testbench
===============================

// Module: dco_ctrl_enc
// PURPOSE
//  Upstream control stage of the DCO. Takes the loop-filter tuning words for
//  the PVT (large), acquisition (medium) and tracking (small) capacitor banks
//  and sequences the bank modes. Drives the r_all/row/col matrix-select buses
//  of the 5x5 L bank and the 16x16 M and S banks.
//  The tracking bank adds a first-order sigma-delta dither on the fractional
//  bits of its tuning word. Runs on the retimed reference clock.
// PARAMETERS
//  FRAC     4    fractional bits of trk_word (dithered)
//  L_INIT   12   L-bank code loaded at reset / entry to PVT (0..25)
//  M_INIT   128  M-bank code loaded at reset / entry to PVT (0..256)
//  S_INIT   128  S-bank integer code loaded at reset / entry to PVT (0..255)
// PORTS
//  clk        in   1        retimed reference clock
//  rst        in   1        synchronous reset, active high
//  en         in   1        loop enable
//  pvt_word   in   5        L-bank code request
//  pvt_load   in   1        capture pvt_word (honoured in PVT state only)
//  pvt_done   in   1        pulse: freeze L bank, go to ACQ
//  acq_word   in   8        M-bank code request
//  acq_load   in   1        capture acq_word (ACQ only)
//  acq_done   in   1        pulse: freeze M bank, go to TRK
//  trk_word   in   8+FRAC   S-bank code, unsigned {int[7:0],frac}
//  trk_load   in   1        capture trk_word (TRK only)
//  dith_en    in   1        enable sigma-delta dither of frac bits
//  dco_en     out  1        DCO enable, registered, =1 in PVT/ACQ/TRK
//  mode       out  2        0=OFF 1=PVT 2=ACQ 3=TRK
//  c_l_r_all, c_l_row, c_l_col  out  5   L-bank select buses
//  c_m_r_all, c_m_row, c_m_col  out  16  M-bank select buses
//  c_s_r_all, c_s_row, c_s_col  out  16  S-bank select buses
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (rst).
//  - Cell rule: a cell is on = r_all[i] | (row[i] & col[j]). For count N in a
//    KxK bank: q=N/K, r=N%K; r_all[i]=(i<q); row[i]=(i==q)&&(r!=0); col[j]=(j<r).
//    N=0 gives all zeros; N=K*K gives r_all all ones, row=col=0.
//  - Reset: state OFF, mode=0, dco_en=0, dither acc=0, word registers=INIT.
//    All buses show the encoded INIT codes one edge after rst is sampled high.
//    With defaults the L bus is r_all=00011, row=00100, col=00011; the M bus is
//    r_all=0x00FF, row=0, col=0.
//  - FSM (evaluated each edge):
//      OFF->PVT on en=1; bank words reload INIT on entry.
//      PVT->ACQ on pvt_done.
//      ACQ->TRK on acq_done.
//      any->OFF on en=0, which has priority over done pulses.
//      Done pulses in other states are ignored.
//      rst has priority over everything.
//  - Loads: a word is captured at edge n only when its load is high in the
//    owning state. Its code appears on the buses after edge n+1, a fixed
//    1-cycle pipeline. Out-of-state loads are ignored. A frozen bank holds.
//  - Saturation: pvt_word>25 is clamped to 25; acq_word is used as-is (0..255).
//  - Dither (TRK with dith_en=1): each edge {c,acc} <= acc + frac (FRAC+1 bits).
//    S count = int + c, range 0..256; 256 selects all cells, never wraps.
//    With dith_en=0 or outside TRK: c=0 and acc is held.
//    acc is cleared on reset and on entry to PVT.
//  - OFF: dco_en=0; buses keep the last codes (the DCO gates on en).
//  - Simultaneous trk_load and dither carry: the carry applies to the newly
//    captured int. acc is not cleared by a load.
//  - All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  T1 reset: rst=1 for 2 cycles -> mode=0, dco_en=0, L r_all=00011/row=00100/col=00011,
//     M r_all=0x00FF.
//  T2 PVT: en=1, then pvt_load with pvt_word=31 -> L r_all=11111, row=0, col=0
//     (25 cells) two edges after the load; pvt_word=7 -> r_all=00001, row=00010, col=00011.
//  T3 freeze: pvt_done, then pvt_load with 3 in ACQ -> L unchanged; acq_load with 200
//     -> M r_all=0x0FFF, row=0x1000, col=0x00FF.
//  T4 dither: TRK, trk_word={100,4'b0100}, dith_en=1, 64 cycles -> S count 101 in
//     exactly 16 cycles, 100 otherwise, with period 4.
//  T5 edge: trk_word={255,4'b1000} -> S alternates 255/256; at 256 r_all=0xFFFF,
//     row=col=0.
//  T6 abort: en=0 coincident with acq_done -> mode=0, dco_en=0 next edge.
//     Re-enable -> PVT with INIT codes and acc=0. Assert rst mid-TRK -> same
//     result as T1.

Source files
------------

// File: rtl/dco_ctrl_enc.sv
// DCO upstream control: sequences the L/M/S capacitor bank modes, holds
// the bank tuning words, applies first-order sigma-delta dither on the
// tracking bank fraction and encodes each count onto the r_all/row/col
// matrix-select buses.

// Thermometer-to-matrix encoder for one KxK bank (combinational).
module dco_bank_enc #(
  parameter int K  = 16,
  parameter int NW = 9
) (
  input  logic [NW-1:0] cnt,
  output logic [K-1:0]  r_all,
  output logic [K-1:0]  row,
  output logic [K-1:0]  col
);
  logic [NW-1:0] q;
  logic [NW-1:0] r;

  assign q = cnt / NW'(K);
  assign r = cnt % NW'(K);

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_line
      // full rows below q, partial row at q, r leading columns in that row
      assign r_all[gi] = (q > NW'(gi));
      assign row[gi]   = (q == NW'(gi)) && (r != '0);
      assign col[gi]   = (r > NW'(gi));
    end
  endgenerate
endmodule

module dco_ctrl_enc #(
  parameter int FRAC   = 4,
  parameter int L_INIT = 12,
  parameter int M_INIT = 128,
  parameter int S_INIT = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [4:0]        pvt_word,
  input  logic              pvt_load,
  input  logic              pvt_done,
  input  logic [7:0]        acq_word,
  input  logic              acq_load,
  input  logic              acq_done,
  input  logic [8+FRAC-1:0] trk_word,
  input  logic              trk_load,
  input  logic              dith_en,
  output logic              dco_en,
  output logic [1:0]        mode,
  output logic [4:0]        c_l_r_all,
  output logic [4:0]        c_l_row,
  output logic [4:0]        c_l_col,
  output logic [15:0]       c_m_r_all,
  output logic [15:0]       c_m_row,
  output logic [15:0]       c_m_col,
  output logic [15:0]       c_s_r_all,
  output logic [15:0]       c_s_row,
  output logic [15:0]       c_s_col
);
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_PVT = 2'd1, ST_ACQ = 2'd2, ST_TRK = 2'd3} state_t;

  state_t          state_reg;
  logic            dco_en_reg;
  logic [4:0]      l_word_reg;
  logic [8:0]      m_word_reg;
  logic [7:0]      s_int_reg;
  logic [FRAC-1:0] s_frac_reg;
  logic [FRAC-1:0] acc_reg;
  logic            carry_reg;

  logic [4:0]      pvt_clamped;
  logic [FRAC:0]   dith_sum;
  logic [4:0]      l_cnt;
  logic [8:0]      m_cnt;
  logic [8:0]      s_cnt;
  logic [4:0]      l_r_all_next, l_row_next, l_col_next;
  logic [15:0]     m_r_all_next, m_row_next, m_col_next;
  logic [15:0]     s_r_all_next, s_row_next, s_col_next;

  assign pvt_clamped = (pvt_word > 5'd25) ? 5'd25 : pvt_word;
  assign dith_sum    = {1'b0, acc_reg} + {1'b0, s_frac_reg};

  // During reset the encoders see the INIT codes directly so the buses
  // settle one edge after rst, not two.
  assign l_cnt = rst ? 5'(L_INIT) : l_word_reg;
  assign m_cnt = rst ? 9'(M_INIT) : m_word_reg;
  assign s_cnt = rst ? 9'(S_INIT) : ({1'b0, s_int_reg} + {8'd0, carry_reg});

  dco_bank_enc #(.K(5),  .NW(5)) u_enc_l (.cnt(l_cnt), .r_all(l_r_all_next), .row(l_row_next), .col(l_col_next));
  dco_bank_enc #(.K(16), .NW(9)) u_enc_m (.cnt(m_cnt), .r_all(m_r_all_next), .row(m_row_next), .col(m_col_next));
  dco_bank_enc #(.K(16), .NW(9)) u_enc_s (.cnt(s_cnt), .r_all(s_r_all_next), .row(s_row_next), .col(s_col_next));

  // Mode FSM, word capture and dither accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_OFF;
      dco_en_reg <= 1'b0;
      l_word_reg <= 5'(L_INIT);
      m_word_reg <= 9'(M_INIT);
      s_int_reg  <= 8'(S_INIT);
      s_frac_reg <= '0;
      acc_reg    <= '0;
      carry_reg  <= 1'b0;
    end else begin
      // carry is only live while dithering in TRK; acc holds otherwise
      carry_reg <= 1'b0;
      if (state_reg == ST_TRK && dith_en) begin
        {carry_reg, acc_reg} <= dith_sum;
      end
      if (state_reg == ST_PVT && pvt_load) l_word_reg <= pvt_clamped;
      if (state_reg == ST_ACQ && acq_load) m_word_reg <= {1'b0, acq_word};
      if (state_reg == ST_TRK && trk_load) {s_int_reg, s_frac_reg} <= trk_word;

      if (!en) begin
        state_reg  <= ST_OFF;
        dco_en_reg <= 1'b0;
      end else begin
        dco_en_reg <= 1'b1;
        case (state_reg)
          ST_OFF: begin
            state_reg  <= ST_PVT;
            l_word_reg <= 5'(L_INIT);
            m_word_reg <= 9'(M_INIT);
            s_int_reg  <= 8'(S_INIT);
            s_frac_reg <= '0;
            acc_reg    <= '0;
          end
          ST_PVT:  if (pvt_done) state_reg <= ST_ACQ;
          ST_ACQ:  if (acq_done) state_reg <= ST_TRK;
          default: state_reg <= ST_TRK;
        endcase
      end
    end
  end

  // Registered bus outputs: one-cycle pipeline behind the word registers.
  always_ff @(posedge clk) begin
    c_l_r_all <= l_r_all_next;
    c_l_row   <= l_row_next;
    c_l_col   <= l_col_next;
    c_m_r_all <= m_r_all_next;
    c_m_row   <= m_row_next;
    c_m_col   <= m_col_next;
    c_s_r_all <= s_r_all_next;
    c_s_row   <= s_row_next;
    c_s_col   <= s_col_next;
  end

  assign mode   = state_reg;
  assign dco_en = dco_en_reg;
endmodule

// File: tb/tb_dco_ctrl_enc.sv
// Scoreboard bench for dco_ctrl_enc: a cycle model pushes the expected
// outputs for every edge, which are popped and compared after the edge;
// spot checks pin the documented bus patterns.
module tb_dco_ctrl_enc;
  localparam int FRAC = 4;

  logic              clk = 1'b0;
  logic              rst, en, pvt_load, pvt_done, acq_load, acq_done, trk_load, dith_en;
  logic [4:0]        pvt_word;
  logic [7:0]        acq_word;
  logic [8+FRAC-1:0] trk_word;
  logic              dco_en;
  logic [1:0]        mode;
  logic [4:0]        c_l_r_all, c_l_row, c_l_col;
  logic [15:0]       c_m_r_all, c_m_row, c_m_col, c_s_r_all, c_s_row, c_s_col;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  mode;
    logic        dco;
    logic [14:0] l;
    logic [47:0] m;
    logic [47:0] s;
  } exp_t;
  exp_t sb_q[$];

  // model state
  int m_st, m_l, m_m, m_si, m_sf, m_acc, m_c;

  dco_ctrl_enc #(.FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .en(en),
    .pvt_word(pvt_word), .pvt_load(pvt_load), .pvt_done(pvt_done),
    .acq_word(acq_word), .acq_load(acq_load), .acq_done(acq_done),
    .trk_word(trk_word), .trk_load(trk_load), .dith_en(dith_en),
    .dco_en(dco_en), .mode(mode),
    .c_l_r_all(c_l_r_all), .c_l_row(c_l_row), .c_l_col(c_l_col),
    .c_m_r_all(c_m_r_all), .c_m_row(c_m_row), .c_m_col(c_m_col),
    .c_s_r_all(c_s_r_all), .c_s_row(c_s_row), .c_s_col(c_s_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Fill cells row by row: whole rows first, then the partial row's columns.
  function automatic logic [47:0] enc_ref(input int n, input int k);
    logic [15:0] ra = '0, rw = '0, cl = '0;
    int rem = n;
    for (int i = 0; i < k; i++) begin
      if (rem >= k) begin
        ra[i] = 1'b1;
        rem -= k;
      end else if (rem > 0) begin
        rw[i] = 1'b1;
        for (int j = 0; j < rem; j++) cl[j] = 1'b1;
        rem = 0;
      end
    end
    return {ra, rw, cl};
  endfunction

  function automatic logic [14:0] l_ref(input int n);
    logic [47:0] e = enc_ref(n, 5);
    return {e[36:32], e[20:16], e[4:0]};
  endfunction

  function automatic int s_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += c_s_r_all[i] ? 16 : 0;
    if (c_s_row != 16'd0) n += $countones(c_s_col);
    return n;
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    exp_t e;
    int sum;
    if (rst) begin
      m_st = 0; m_l = 12; m_m = 128; m_si = 128; m_sf = 0; m_acc = 0; m_c = 0;
      e.l = l_ref(12); e.m = enc_ref(128, 16); e.s = enc_ref(128, 16);
    end else begin
      e.l = l_ref(m_l); e.m = enc_ref(m_m, 16); e.s = enc_ref(m_si + m_c, 16);
      if (m_st == 3 && dith_en) begin
        sum = m_acc + m_sf;
        m_acc = sum % 16;
        m_c = sum / 16;
      end else m_c = 0;
      if (m_st == 1 && pvt_load) m_l = (pvt_word > 25) ? 25 : int'(pvt_word);
      if (m_st == 2 && acq_load) m_m = int'(acq_word);
      if (m_st == 3 && trk_load) begin
        m_si = int'(trk_word[FRAC+7:FRAC]);
        m_sf = int'(trk_word[FRAC-1:0]);
      end
      if (!en) m_st = 0;
      else if (m_st == 0) begin
        m_st = 1; m_l = 12; m_m = 128; m_si = 128; m_sf = 0; m_acc = 0;
      end else if (m_st == 1 && pvt_done) m_st = 2;
      else if (m_st == 2 && acq_done) m_st = 3;
    end
    e.mode = 2'(m_st);
    e.dco  = (m_st != 0);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_mode", {61'd0, mode, dco_en}, {61'd0, e.mode, e.dco});
    chk("sb_l", {49'd0, c_l_r_all, c_l_row, c_l_col}, {49'd0, e.l});
    chk("sb_m", {16'd0, c_m_r_all, c_m_row, c_m_col}, {16'd0, e.m});
    chk("sb_s", {16'd0, c_s_r_all, c_s_row, c_s_col}, {16'd0, e.s});
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_mode"}, {62'd0, mode}, 64'd0);
    chk({tag, "_dco"}, {63'd0, dco_en}, 64'd0);
    chk({tag, "_l"}, {49'd0, c_l_r_all, c_l_row, c_l_col}, {49'd0, 5'b00011, 5'b00100, 5'b00011});
    chk({tag, "_m_rall"}, {48'd0, c_m_r_all}, 64'h00FF);
    chk({tag, "_s_rall"}, {48'd0, c_s_r_all}, 64'h00FF);
  endtask

  initial begin
    int n101, n100, n256, n255;
    bit seen;
    rst = 1; en = 0; pvt_word = 0; pvt_load = 0; pvt_done = 0;
    acq_word = 0; acq_load = 0; acq_done = 0; trk_word = 0; trk_load = 0; dith_en = 0;

    // T1 reset
    tick(); tick();
    check_reset_state("t1");
    rst = 0;
    tick();

    // T2 PVT loads with clamp
    en = 1; tick();
    pvt_word = 31; pvt_load = 1; tick();
    pvt_load = 0; tick();
    chk("t2_clamp", {49'd0, c_l_r_all, c_l_row, c_l_col}, {49'd0, 5'b11111, 5'b00000, 5'b00000});
    pvt_word = 7; pvt_load = 1; tick();
    pvt_load = 0; tick();
    chk("t2_seven", {49'd0, c_l_r_all, c_l_row, c_l_col}, {49'd0, 5'b00001, 5'b00010, 5'b00011});

    // T3 freeze L, load M in ACQ
    pvt_done = 1; tick();
    pvt_done = 0; pvt_word = 3; pvt_load = 1; tick();
    pvt_load = 0; tick(); tick();
    chk("t3_frozen", {49'd0, c_l_r_all, c_l_row, c_l_col}, {49'd0, 5'b00001, 5'b00010, 5'b00011});
    acq_word = 200; acq_load = 1; tick();
    acq_load = 0; tick();
    chk("t3_m200", {16'd0, c_m_r_all, c_m_row, c_m_col}, {16'd0, 16'h0FFF, 16'h1000, 16'h00FF});

    // T4 dither 100 + 4/16
    acq_done = 1; tick();
    acq_done = 0; trk_word = {8'd100, 4'b0100}; trk_load = 1; tick();
    trk_load = 0; dith_en = 1; tick(); tick();
    n101 = 0; n100 = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (s_count() == 101) n101++;
      else if (s_count() == 100) n100++;
    end
    chk("t4_n101", 64'(n101), 64'd16);
    chk("t4_n100", 64'(n100), 64'd48);

    // T5 top edge 255 + 8/16
    trk_word = {8'd255, 4'b1000}; trk_load = 1; tick();
    trk_load = 0; tick();
    n256 = 0; n255 = 0; seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_count() == 256) begin
        n256++;
        if (!seen) begin
          seen = 1;
          chk("t5_full", {16'd0, c_s_r_all, c_s_row, c_s_col}, {16'd0, 16'hFFFF, 16'h0000, 16'h0000});
        end
      end else if (s_count() == 255) n255++;
    end
    chk("t5_n256", 64'(n256), 64'd4);
    chk("t5_n255", 64'(n255), 64'd4);

    // T6 abort with en=0 beating acq_done
    en = 0; tick();
    en = 1; tick();
    pvt_done = 1; tick();
    pvt_done = 0; en = 0; acq_done = 1; tick();
    chk("t6_abort_mode", {62'd0, mode}, 64'd0);
    chk("t6_abort_dco", {63'd0, dco_en}, 64'd0);
    acq_done = 0; en = 1; tick(); tick();
    chk("t6_reen_mode", {62'd0, mode}, 64'd1);
    chk("t6_reen_l", {49'd0, c_l_r_all, c_l_row, c_l_col}, {49'd0, 5'b00011, 5'b00100, 5'b00011});
    chk("t6_reen_m", {48'd0, c_m_r_all}, 64'h00FF);
    pvt_done = 1; tick();
    pvt_done = 0; acq_done = 1; tick();
    acq_done = 0; trk_word = {8'd40, 4'b0111}; trk_load = 1; tick();
    trk_load = 0; tick(); tick(); tick();
    chk("t6_trk_mode", {62'd0, mode}, 64'd3);
    rst = 1; tick(); tick();
    check_reset_state("t6_rst");
    rst = 0; en = 0; dith_en = 0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
